util_pulse_train: RTL and testbench
===================================

UTIL_PULSE_TRAIN -- requirements
Module: util_pulse_train

Interface
REQ-001 Parameter: W, default 8, width of the length and count fields and of the internal counters.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 res  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 start  input  1  request to emit a pulse train; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled in every state.
REQ-006 high_len  input  W  cycles out is high per pulse; latched on accepted start.
REQ-007 low_len  input  W  cycles out is low between pulses; latched on accepted start.
REQ-008 count  input  W  number of pulses in the train; latched on accepted start.
REQ-009 out  output  1  registered pulse-train output, glitch-free.
REQ-010 busy  output  1  registered; high while a train is in progress.
REQ-011 done  output  1  registered; one-cycle strobe on normal train completion.

Function
REQ-012 The block SHALL implement three states: IDLE, HIGH and LOW.
REQ-013 In IDLE, start=1, stop=0 and count!=0 at edge k SHALL latch high_len, low_len and count, then enter HIGH with out=1 and busy=1 from cycle k+1.
REQ-014 high_len=0 and low_len=0 SHALL each be treated as 1.
REQ-015 HIGH SHALL last exactly max(high_len,1) cycles with out=1.
REQ-016 Leaving HIGH with pulses remaining SHALL enter LOW, with out=0 for exactly max(low_len,1) cycles, then re-enter HIGH.
REQ-017 Leaving HIGH after the last pulse SHALL skip LOW and go directly to IDLE: out=0, busy=0 and done=1 in that same first IDLE cycle.
REQ-018 done SHALL be high for exactly one cycle per completed train.
REQ-019 The total busy duration SHALL be N*H + (N-1)*L cycles, where N=count, H=max(high_len,1) and L=max(low_len,1).
REQ-020 start with count=0 SHALL emit no pulse, keep busy=0, and assert done for one cycle at k+1.
REQ-021 start while busy=1 SHALL be ignored; no queuing.
REQ-022 Changes to high_len, low_len or count during a train SHALL have no effect on that train.
REQ-023 stop=1 in HIGH or LOW SHALL return to IDLE on the next edge with out=0, busy=0 and no done.
REQ-024 stop=1 together with start=1 in IDLE SHALL win: the start is not accepted and done is not asserted.
REQ-025 start held high SHALL begin a new train in the cycle after done, i.e. one idle cycle between trains, back-to-back.
REQ-026 Counters SHALL be W bits wide and never wrap: count=2^W-1 produces exactly 2^W-1 pulses, and high_len=2^W-1 gives exactly 2^W-1 high cycles.
REQ-027 out, busy and done SHALL be driven directly from flip-flops, with no combinational path from any input.

Reset
REQ-028 res=0 SHALL immediately, asynchronously, force state IDLE, out=0, busy=0, done=0 and all counters and latched fields to 0.
REQ-029 Reset asserted mid-train SHALL abort the train with no done.
REQ-030 After res returns to 1, the first start SHALL be accepted at the first rising edge.

Verification
REQ-031 high_len=2, low_len=3, count=3, start pulse at edge 0 -> out high in cycles 1-2, 6-7, 11-12; busy high cycles 1-12; done=1 at cycle 13 only.
REQ-032 high_len=0, low_len=0, count=4 -> out alternates 1,0,1,0,1,0,1 from cycle 1; done at cycle 8.
REQ-033 count=0, start -> out stays 0, busy stays 0, done=1 at cycle 1.
REQ-034 high_len=5, count=2, stop asserted in cycle 3 -> out=0 and busy=0 from cycle 4; done never asserts; a start in cycle 5 is accepted.
REQ-035 Same config as REQ-031 with res driven 0 in cycle 7 -> out, busy and done go 0 immediately without waiting for clk; stay 0 until a new start after res=1.
REQ-036 start held high with count=1, high_len=1 -> out pattern 1,0,1,0,... with done coinciding with each out=0 cycle; start pulses issued while busy are ignored.

Source files
------------

// File: rtl/util_pulse_train.sv
// Programmable pulse-train generator: emits count pulses of high_len cycles
// separated by low_len cycles. A zero length counts as one cycle.
module util_pulse_train #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] high_len,
  input  logic [W-1:0] low_len,
  input  logic [W-1:0] count,
  output logic         out,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_high;
  logic [W-1:0]   r_low;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_tmr;
  logic [W-1:0]   w_high_eff;
  logic [W-1:0]   w_low_eff;

  assign w_high_eff = (high_len == ZERO) ? ONE : high_len;
  assign w_low_eff  = (low_len  == ZERO) ? ONE : low_len;

  // Sequencer: r_tmr holds the cycles left in the current phase, r_cnt the
  // pulses left including the one in progress.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= IDLE;
      r_high  <= ZERO;
      r_low   <= ZERO;
      r_cnt   <= ZERO;
      r_tmr   <= ZERO;
      out     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            if (count == ZERO) begin
              done <= 1'b1;
            end else begin
              r_high  <= w_high_eff;
              r_low   <= w_low_eff;
              r_cnt   <= count;
              r_tmr   <= w_high_eff;
              out     <= 1'b1;
              busy    <= 1'b1;
              r_state <= HIGH;
            end
          end else begin
            out  <= 1'b0;
            busy <= 1'b0;
          end
        end
        HIGH: begin
          if (stop) begin
            out     <= 1'b0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (r_tmr == ONE) begin
            out <= 1'b0;
            if (r_cnt == ONE) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_cnt   <= r_cnt - ONE;
              r_tmr   <= r_low;
              r_state <= LOW;
            end
          end else begin
            r_tmr <= r_tmr - ONE;
          end
        end
        LOW: begin
          if (stop) begin
            out     <= 1'b0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (r_tmr == ONE) begin
            r_tmr   <= r_high;
            out     <= 1'b1;
            r_state <= HIGH;
          end else begin
            r_tmr <= r_tmr - ONE;
          end
        end
        default: begin
          out     <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_util_pulse_train.sv
// Directed bench for util_pulse_train: expected {out,busy,done} per cycle are
// queued from a closed-form train model and compared on the falling edge.
module tb_util_pulse_train;

  logic       clk;
  logic       res;
  logic       start;
  logic       stop;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] count;
  logic       out;
  logic       busy;
  logic       done;

  int tests;
  int fails;
  logic [2:0] q[$];

  util_pulse_train #(.W(8)) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .stop     (stop),
    .high_len (high_len),
    .low_len  (low_len),
    .count    (count),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {out,busy,done} for a full train of n pulses, h high, l low, then done.
  task automatic push_train(input int n, input int h, input int l);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) q.push_back(3'b110);
      if (p < n - 1) begin
        for (int i = 0; i < l; i++) q.push_back(3'b010);
      end
    end
    q.push_back(3'b001);
  endtask

  task automatic push_n(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) q.push_back(v);
  endtask

  task automatic check(input string tag);
    logic [2:0] exp;
    logic [2:0] obs;
    exp = (q.size() != 0) ? q.pop_front() : 3'bxxx;
    obs = {out, busy, done};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0t observed {out,busy,done}=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    res = 1'b0; start = 1'b0; stop = 1'b0;
    high_len = 8'd0; low_len = 8'd0; count = 8'd0;

    push_n(3'b000, 2);
    run(2, "reset_state");

    // Release reset and start at once: first edge must accept.
    res = 1'b1; high_len = 8'd2; low_len = 8'd3; count = 8'd3; start = 1'b1;
    push_train(3, 2, 3); push_n(3'b000, 1);
    run(1, "h2l3n3");
    start = 1'b0; high_len = 8'd7; low_len = 8'd1; count = 8'd9;
    run(3, "h2l3n3");
    start = 1'b1;
    run(1, "start_while_busy");
    start = 1'b0;
    run(9, "h2l3n3");

    high_len = 8'd0; low_len = 8'd0; count = 8'd4; start = 1'b1;
    push_train(4, 1, 1); push_n(3'b000, 1);
    run(1, "zero_len");
    start = 1'b0;
    run(8, "zero_len");

    count = 8'd0; start = 1'b1;
    push_n(3'b001, 1); push_n(3'b000, 1);
    run(1, "count0");
    start = 1'b0;
    run(1, "count0");

    high_len = 8'd5; low_len = 8'd2; count = 8'd2; start = 1'b1;
    push_n(3'b110, 3); push_n(3'b000, 2);
    run(1, "stop_high");
    start = 1'b0;
    run(2, "stop_high");
    stop = 1'b1;
    run(1, "stop_high");
    stop = 1'b0;
    run(1, "stop_high");
    high_len = 8'd1; count = 8'd1; start = 1'b1;
    push_train(1, 1, 1); push_n(3'b000, 1);
    run(1, "start_after_stop");
    start = 1'b0;
    run(2, "start_after_stop");

    high_len = 8'd1; low_len = 8'd4; count = 8'd2; start = 1'b1;
    push_n(3'b110, 1); push_n(3'b010, 2); push_n(3'b000, 2);
    run(1, "stop_low");
    start = 1'b0;
    run(2, "stop_low");
    stop = 1'b1;
    run(1, "stop_low");
    stop = 1'b0;
    run(1, "stop_low");

    stop = 1'b1; start = 1'b1; count = 8'd2;
    push_n(3'b000, 2);
    run(1, "stop_wins");
    stop = 1'b0; start = 1'b0;
    run(1, "stop_wins");

    high_len = 8'd2; low_len = 8'd3; count = 8'd3; start = 1'b1;
    q.push_back(3'b110); q.push_back(3'b110);
    push_n(3'b010, 3);
    q.push_back(3'b110); q.push_back(3'b110);
    run(1, "rst_mid");
    start = 1'b0;
    run(6, "rst_mid");
    #2 res = 1'b0;
    #1 q.push_back(3'b000);
    check("rst_async");
    start = 1'b1;
    push_n(3'b000, 2);
    run(2, "rst_hold");
    res = 1'b1; start = 1'b0;
    push_n(3'b000, 1);
    run(1, "rst_idle");
    high_len = 8'd1; count = 8'd1; start = 1'b1;
    push_train(1, 1, 1); push_n(3'b000, 1);
    run(1, "rst_restart");
    start = 1'b0;
    run(2, "rst_restart");

    high_len = 8'd1; low_len = 8'd1; count = 8'd1; start = 1'b1;
    for (int i = 0; i < 3; i++) push_train(1, 1, 1);
    run(6, "b2b");
    start = 1'b0;
    push_n(3'b000, 1);
    run(1, "b2b");

    high_len = 8'd255; low_len = 8'd9; count = 8'd1; start = 1'b1;
    push_train(1, 255, 9); push_n(3'b000, 1);
    run(1, "high_max");
    start = 1'b0;
    run(256, "high_max");

    high_len = 8'd1; low_len = 8'd1; count = 8'd255; start = 1'b1;
    push_train(255, 1, 1); push_n(3'b000, 1);
    run(1, "count_max");
    start = 1'b0;
    run(510, "count_max");

    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL queue_drain observed=%0d expected=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
